// File: rtl/ks10_mem_responder.sv
// KS10 main-memory responder: accepts read/write/RPW requests, inserts wait states,
// and completes with a one-cycle ack, or a one-cycle NXM pulse on errors.
module ks10_mem_responder #(
    parameter int ADDR_WIDTH  = 20,
    parameter int MEM_WORDS   = 4096,
    parameter int WAIT_STATES = 2,
    parameter int RPW_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bus_req,
    input  logic                  bus_read,
    input  logic                  bus_write,
    input  logic                  bus_rpw,
    input  logic [ADDR_WIDTH-1:0] bus_addr,
    input  logic [35:0]           bus_data_in,
    output logic                  bus_ack,
    output logic [35:0]           bus_data_out,
    output logic                  bus_nxm,
    output logic                  busy,
    output logic                  rpw_locked
);

    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int CW    = $clog2(WAIT_STATES + 2);
    localparam int TW    = $clog2(RPW_TIMEOUT + 2);
    localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_WORDS);

    typedef enum logic [2:0] {IDLE, WAIT, DONE, RPW_HOLD, RPW_WRITE, ERR} state_t;
    typedef enum logic [1:0] {CMD_READ, CMD_WRITE, CMD_RPW} cmd_t;

    state_t                state;
    cmd_t                  lat_cmd;
    logic [CW-1:0]         wcnt;
    logic [TW-1:0]         tcnt;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [35:0]           lat_data;
    logic [35:0]           mem [MEM_WORDS];

    logic                  legal;
    logic                  wr_only;
    cmd_t                  bus_cmd;
    logic [ADDR_WIDTH-1:0] c_addr;
    logic [35:0]           c_data;
    cmd_t                  c_cmd;
    logic                  in_range;
    logic                  complete;
    logic                  rpw_commit;
    logic                  mem_we;
    logic [35:0]           mem_wdata;
    logic [IDX_W-1:0]      mem_idx;

    assign legal   = (bus_read ^ bus_write ^ bus_rpw) & ~(bus_read & bus_write & bus_rpw);
    assign wr_only = bus_write & ~bus_read & ~bus_rpw;
    assign bus_cmd = bus_read ? CMD_READ : (bus_write ? CMD_WRITE : CMD_RPW);

    // With zero wait states a transaction completes on the accepting edge, so the
    // completion path looks at the live bus while idle and at the latches otherwise.
    assign c_addr   = (state == IDLE) ? bus_addr : lat_addr;
    assign c_data   = (state == IDLE) ? bus_data_in : lat_data;
    assign c_cmd    = (state == IDLE) ? bus_cmd : lat_cmd;
    assign in_range = {1'b0, c_addr} < MEM_LIMIT;

    assign complete   = (state == WAIT && wcnt == CW'(1)) ||
                        (WAIT_STATES == 0 && state == IDLE && bus_req && legal);
    assign rpw_commit = (state == RPW_WRITE && wcnt == CW'(1)) ||
                        (WAIT_STATES == 0 && state == RPW_HOLD && bus_req && wr_only);

    assign mem_we    = rst && (rpw_commit || (complete && in_range && c_cmd == CMD_WRITE));
    assign mem_wdata = (state == RPW_HOLD) ? bus_data_in : c_data;
    assign mem_idx   = c_addr[IDX_W-1:0];

    assign busy       = (state != IDLE);
    assign rpw_locked = (state == RPW_HOLD) || (state == RPW_WRITE);

    // Word array lives outside the reset domain so its contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_idx] <= mem_wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            lat_cmd      <= CMD_READ;
            wcnt         <= '0;
            tcnt         <= '0;
            lat_addr     <= '0;
            lat_data     <= '0;
            bus_ack      <= 1'b0;
            bus_nxm      <= 1'b0;
            bus_data_out <= '0;
        end else begin
            bus_ack <= 1'b0;
            bus_nxm <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus_req) begin
                        lat_addr <= bus_addr;
                        lat_data <= bus_data_in;
                        lat_cmd  <= bus_cmd;
                        if (!legal) begin
                            bus_nxm <= 1'b1;
                            state   <= ERR;
                        end else begin
                            wcnt  <= CW'(WAIT_STATES);
                            state <= WAIT;
                        end
                    end
                end
                WAIT, RPW_WRITE: wcnt <= wcnt - CW'(1);
                DONE, ERR:       state <= IDLE;
                RPW_HOLD: begin
                    if (bus_req && wr_only) begin
                        lat_data <= bus_data_in;
                        wcnt     <= CW'(WAIT_STATES);
                        state    <= RPW_WRITE;
                    end else begin
                        if (bus_req)
                            bus_nxm <= 1'b1;
                        if (tcnt == TW'(1)) begin
                            bus_nxm <= 1'b1;
                            state   <= ERR;
                        end else begin
                            tcnt <= tcnt - TW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // Completion overrides the state chosen above.
            if (complete) begin
                if (!in_range) begin
                    bus_nxm <= 1'b1;
                    state   <= DONE;
                end else begin
                    case (c_cmd)
                        CMD_READ: begin
                            bus_data_out <= mem[mem_idx];
                            bus_ack      <= 1'b1;
                            state        <= DONE;
                        end
                        CMD_WRITE: begin
                            bus_ack <= 1'b1;
                            state   <= DONE;
                        end
                        CMD_RPW: begin
                            bus_data_out <= mem[mem_idx];
                            bus_ack      <= 1'b1;
                            tcnt         <= TW'(RPW_TIMEOUT);
                            state        <= RPW_HOLD;
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
            if (rpw_commit) begin
                bus_ack <= 1'b1;
                state   <= DONE;
            end
        end
    end

endmodule
